// File: rtl/sr_univ_pkg.sv
// Shared definitions for the universal register: mode encodings and the
// per-bit set/reset resolution used by every storage cell.
package sr_univ_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_UP   = 3'd4;
    localparam logic [2:0] MODE_DOWN = 3'd5;
    localparam logic [2:0] MODE_ROL  = 3'd6;
    localparam logic [2:0] MODE_ROR  = 3'd7;

    // Set wins alone, reset wins alone, both together freeze the bit,
    // neither lets the mode result through.
    function automatic logic sr_resolve(input logic cur, input logic s,
                                        input logic r, input logic mode_bit);
        logic nxt;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11:   nxt = cur;
            default: nxt = mode_bit;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_bit_cell.sv
// One storage bit: a flop whose next value is the mode result unless the
// bit's own set/reset inputs override it.
module sr_bit_cell
    import sr_univ_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    input  logic nxt,
    output logic q,
    output logic conflict
);

    assign conflict = s & r;

    // Reset first, then set/reset override, then the mode result.
    always_ff @(posedge clk) begin
        if (rst) q <= RESET_BIT;
        else     q <= sr_resolve(q, s, r, nxt);
    end

endmodule

// File: rtl/sr_univ_reg.sv
// Universal register: hold, load, shift, rotate and up/down count over
// WIDTH bits, with per-bit synchronous set/reset and a sticky flag that
// records any bit seeing set and reset together.
module sr_univ_reg
    import sr_univ_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic             sout_l,
    output logic             sout_r,
    output logic             tc,
    output logic             sr_conflict
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mode_res;
    logic [WIDTH-1:0] bit_conflict;
    logic             any_conflict;

    // Mode result is always computed from the whole pre-edge q; the cells
    // apply set/reset overrides bit by bit afterwards.
    always_comb begin
        mode_res = q;
        case (mode)
            MODE_HOLD: mode_res = q;
            MODE_LOAD: mode_res = d;
            MODE_SHL:  mode_res = {q[WIDTH-2:0], sin_l};
            MODE_SHR:  mode_res = {sin_r, q[WIDTH-1:1]};
            MODE_UP:   mode_res = q + ONE;
            MODE_DOWN: mode_res = q - ONE;
            MODE_ROL:  mode_res = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  mode_res = {q[0], q[WIDTH-1:1]};
            default:   mode_res = q;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_bit_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .s        (s[i]),
            .r        (r[i]),
            .nxt      (mode_res[i]),
            .q        (q[i]),
            .conflict (bit_conflict[i])
        );
    end

    assign any_conflict = |bit_conflict;

    assign qnot   = ~q;
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign tc     = ((mode == MODE_UP)   && (&q)) ||
                    ((mode == MODE_DOWN) && (~|q));

    // Sticky conflict flag: a new conflict beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)               sr_conflict <= 1'b0;
        else if (any_conflict) sr_conflict <= 1'b1;
        else if (clr_err)      sr_conflict <= 1'b0;
    end

endmodule

// File: tb/tb_sr_univ_reg.sv
// Bench for sr_univ_reg (WIDTH=8, RESET_VAL=A5): stimulus pushes expected
// register/flag values into a queue, each scenario pops and compares.
module tb_sr_univ_reg;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_l;
    logic         sin_r;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         clr_err;
    logic [W-1:0] q;
    logic [W-1:0] qnot;
    logic         sout_l;
    logic         sout_r;
    logic         tc;
    logic         sr_conflict;

    sr_univ_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .s(s), .r(r), .clr_err(clr_err), .q(q), .qnot(qnot), .sout_l(sout_l),
        .sout_r(sout_r), .tc(tc), .sr_conflict(sr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         conf;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_q;
    logic         m_conf;
    int           checks   = 0;
    int           failures = 0;

    function automatic logic m_tc(input logic [2:0] md, input logic [W-1:0] v);
        return ((md == 3'd4) && (v == 8'hFF)) || ((md == 3'd5) && (v == 8'h00));
    endfunction

    // Drive one cycle of inputs, predict the post-edge state, queue it,
    // then wait past the edge.
    task automatic apply(input logic rs, input logic [2:0] md, input logic [W-1:0] dd,
                         input logic sl, input logic sri, input logic [W-1:0] ss,
                         input logic [W-1:0] rr, input logic ce);
        logic [W-1:0] mr;
        logic [W-1:0] nq;
        exp_t         e;
        rst = rs; mode = md; d = dd; sin_l = sl; sin_r = sri; s = ss; r = rr; clr_err = ce;
        case (md)
            3'd0:    mr = m_q;
            3'd1:    mr = dd;
            3'd2:    mr = {m_q[W-2:0], sl};
            3'd3:    mr = {sri, m_q[W-1:1]};
            3'd4:    mr = m_q + 8'd1;
            3'd5:    mr = m_q - 8'd1;
            3'd6:    mr = {m_q[W-2:0], m_q[W-1]};
            default: mr = {m_q[0], m_q[W-1:1]};
        endcase
        for (int i = 0; i < W; i++) begin
            if (ss[i] && !rr[i])      nq[i] = 1'b1;
            else if (rr[i] && !ss[i]) nq[i] = 1'b0;
            else if (ss[i] && rr[i])  nq[i] = m_q[i];
            else                      nq[i] = mr[i];
        end
        if (rs) begin
            nq     = RV;
            e.conf = 1'b0;
        end else if (|(ss & rr)) e.conf = 1'b1;
        else if (ce)             e.conf = 1'b0;
        else                     e.conf = m_conf;
        e.q = nq;
        sb.push_back(e);
        m_q    = nq;
        m_conf = e.conf;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] md, input logic [W-1:0] dd);
        apply(1'b0, md, dd, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_reset;
        exp_t e;
        apply(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        e = sb.pop_front();
        apply(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'hA5) begin failures++; $display("FAIL reset_q actual=%h expected=%h", q, e.q); end
        checks++; if (qnot !== 8'h5A) begin failures++; $display("FAIL reset_qnot actual=%h expected=5a", qnot); end
        checks++; if (sr_conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict actual=%b expected=0", sr_conflict); end
        checks++; if (sout_l !== 1'b1 || sout_r !== 1'b1) begin failures++; $display("FAIL reset_sout actual=%b%b expected=11", sout_l, sout_r); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc actual=%b expected=0", tc); end
    endtask

    task automatic test_load;
        exp_t e;
        op(3'd1, 8'h3C);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'h3C) begin failures++; $display("FAIL load_q actual=%h expected=%h", q, e.q); end
        checks++; if (qnot !== 8'hC3) begin failures++; $display("FAIL load_qnot actual=%h expected=c3", qnot); end
    endtask

    task automatic test_count_wrap;
        exp_t e;
        op(3'd1, 8'hFE);
        e = sb.pop_front();
        checks++; if (q !== e.q) begin failures++; $display("FAIL wrap_load actual=%h expected=%h", q, e.q); end
        mode = 3'd4; #1;
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL tc_fe actual=%b expected=0", tc); end
        op(3'd4, 8'h00);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'hFF) begin failures++; $display("FAIL up_ff actual=%h expected=%h", q, e.q); end
        checks++; if (tc !== 1'b1) begin failures++; $display("FAIL tc_up_ff actual=%b expected=1", tc); end
        op(3'd4, 8'h00);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'h00) begin failures++; $display("FAIL up_wrap actual=%h expected=%h", q, e.q); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL tc_up_00 actual=%b expected=0", tc); end
        mode = 3'd5; #1;
        checks++; if (tc !== 1'b1) begin failures++; $display("FAIL tc_down_00 actual=%b expected=1", tc); end
        op(3'd5, 8'h00);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'hFF) begin failures++; $display("FAIL down_wrap actual=%h expected=%h", q, e.q); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL tc_down_ff actual=%b expected=0", tc); end
    endtask

    task automatic test_shifts;
        logic [2:0] mds [4] = '{3'd2, 3'd3, 3'd6, 3'd7};
        logic [7:0] exps[4] = '{8'h02, 8'hC0, 8'h03, 8'hC0};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            op(3'd1, 8'h81);
            e = sb.pop_front();
            checks++; if (q !== e.q) begin failures++; $display("FAIL shift_load%0d actual=%h expected=%h", k, q, e.q); end
            checks++; if (sout_l !== 1'b1 || sout_r !== 1'b1) begin failures++; $display("FAIL shift_sout%0d actual=%b%b expected=11", k, sout_l, sout_r); end
            apply(1'b0, mds[k], 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
            e = sb.pop_front();
            checks++; if (q !== e.q || q !== exps[k]) begin failures++; $display("FAIL shift_mode%0d actual=%h expected=%h", mds[k], q, exps[k]); end
        end
    endtask

    task automatic test_sr_override;
        exp_t e;
        op(3'd1, 8'h0F);
        e = sb.pop_front();
        apply(1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 8'h80, 8'h00, 1'b0);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'h90) begin failures++; $display("FAIL up_set actual=%h expected=%h", q, e.q); end
        op(3'd1, 8'h0F);
        e = sb.pop_front();
        apply(1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'h10) begin failures++; $display("FAIL up_reset actual=%h expected=%h", q, e.q); end
        apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h04, 8'h04, 1'b0);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'h10) begin failures++; $display("FAIL conflict_hold actual=%h expected=%h", q, e.q); end
        checks++; if (sr_conflict !== 1'b1) begin failures++; $display("FAIL conflict_set actual=%b expected=1", sr_conflict); end
        for (int k = 0; k < 5; k++) begin
            op(3'd0, 8'h00);
            e = sb.pop_front();
            checks++; if (sr_conflict !== e.conf || sr_conflict !== 1'b1) begin failures++; $display("FAIL conflict_sticky%0d actual=%b expected=1", k, sr_conflict); end
        end
    endtask

    task automatic test_clr_err;
        exp_t e;
        apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        e = sb.pop_front();
        checks++; if (sr_conflict !== e.conf || sr_conflict !== 1'b0) begin failures++; $display("FAIL clr_plain actual=%b expected=0", sr_conflict); end
        apply(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h01, 1'b1);
        e = sb.pop_front();
        checks++; if (sr_conflict !== e.conf || sr_conflict !== 1'b1) begin failures++; $display("FAIL clr_vs_conflict actual=%b expected=1", sr_conflict); end
        checks++; if (q !== e.q) begin failures++; $display("FAIL clr_q actual=%h expected=%h", q, e.q); end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        op(3'd1, 8'h10);
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            op(3'd4, 8'h00);
            e = sb.pop_front();
        end
        checks++; if (q !== e.q || q !== 8'h13) begin failures++; $display("FAIL mid_count actual=%h expected=13", q); end
        apply(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'hA5) begin failures++; $display("FAIL mid_reset_q actual=%h expected=a5", q); end
        checks++; if (sr_conflict !== 1'b0) begin failures++; $display("FAIL mid_reset_conf actual=%b expected=0", sr_conflict); end
        op(3'd4, 8'h00);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'hA6) begin failures++; $display("FAIL resume_a6 actual=%h expected=a6", q); end
        op(3'd4, 8'h00);
        e = sb.pop_front();
        checks++; if (q !== e.q || q !== 8'hA7) begin failures++; $display("FAIL resume_a7 actual=%h expected=a7", q); end
    endtask

    task automatic test_back_to_back;
        exp_t       e;
        logic [2:0] md;
        for (int k = 0; k < 80; k++) begin
            md = 3'($urandom_range(0, 7));
            apply(($urandom_range(0, 19) == 0), md, 8'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom & $urandom & $urandom), 8'($urandom & $urandom & $urandom),
                  ($urandom_range(0, 3) == 0));
            e = sb.pop_front();
            checks++; if (q !== e.q) begin failures++; $display("FAIL b2b_q%0d actual=%h expected=%h", k, q, e.q); end
            checks++; if (sr_conflict !== e.conf) begin failures++; $display("FAIL b2b_conf%0d actual=%b expected=%b", k, sr_conflict, e.conf); end
            checks++; if (qnot !== ~e.q || tc !== m_tc(md, e.q)) begin failures++; $display("FAIL b2b_comb%0d qnot=%h tc=%b expected qnot=%h tc=%b", k, qnot, tc, ~e.q, m_tc(md, e.q)); end
        end
    endtask

    initial begin
        m_q    = '0;
        m_conf = 1'b0;
        test_reset();
        test_load();
        test_count_wrap();
        test_shifts();
        test_sr_override();
        test_clr_err();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
